// File: rtl/lcd_frame_streamer_if.sv
// lcd_frame_streamer_if: read port of the video store queue (first-word-fall-through)
//   q_empty : queue empty; q_data is valid only while this is low
//   q_data  : head entry, [16]=SOF tag, [15:0]=RGB565 pixel
//   q_rd_en : pop the head entry this cycle
// master = queue side, slave = consumer (lcd_frame_streamer)
interface lcd_frame_streamer_if;
    logic        q_empty;
    logic [16:0] q_data;
    logic        q_rd_en;
    modport master (output q_empty, output q_data, input q_rd_en);
    modport slave  (input q_empty, input q_data, output q_rd_en);
endinterface

// File: rtl/lcd_frame_streamer.sv
// lcd_frame_streamer: RGB LCD timing generator that streams one queue entry per active pixel,
// locking each output frame to an SOF-tagged entry and emitting FILL_COLOR while unsynced or starved.
//   clk, rst_n          : pixel clock, asynchronous active-low reset
//   q (slave)           : store queue read port (q_empty, q_data[16:0], q_rd_en)
//   lcd_de/hsync/vsync  : registered data enable and active-low syncs
//   lcd_r/g/b           : registered RGB565 pixel split 5/6/5
//   frame_start         : one-cycle pulse with the first pixel of a synced frame
//   underrun            : sticky, set when a streamed active pixel finds the queue empty
//   resync_cnt          : saturating count of lost-alignment events
module lcd_frame_streamer #(
    parameter int          H_ACTIVE   = 480,
    parameter int          H_FP       = 2,
    parameter int          H_SYNC     = 41,
    parameter int          H_BP       = 2,
    parameter int          V_ACTIVE   = 272,
    parameter int          V_FP       = 2,
    parameter int          V_SYNC     = 10,
    parameter int          V_BP       = 2,
    parameter logic [15:0] FILL_COLOR = 16'h0000
) (
    input  logic                clk,
    input  logic                rst_n,
    lcd_frame_streamer_if.slave q,
    output logic                lcd_de,
    output logic                lcd_hsync,
    output logic                lcd_vsync,
    output logic [4:0]          lcd_r,
    output logic [5:0]          lcd_g,
    output logic [4:0]          lcd_b,
    output logic                frame_start,
    output logic                underrun,
    output logic [7:0]          resync_cnt
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    typedef enum logic {WAIT_SOF, STREAM} state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic          de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d;
    logic [15:0]   rgb_q, rgb_d;
    logic          frame_start_q, frame_start_d, underrun_q, underrun_d;
    logic [7:0]    resync_cnt_q, resync_cnt_d;
    logic          active, origin, head_sof, pop, use_data, resync;

    always_comb begin
        active   = (h_cnt_q < HW'(H_ACTIVE)) && (v_cnt_q < VW'(V_ACTIVE));
        origin   = (h_cnt_q == '0) && (v_cnt_q == '0);
        head_sof = !q.q_empty && q.q_data[16];
        // STREAM pops data pixels off-origin and only the SOF at origin; WAIT_SOF drains
        // stale pixels anywhere and takes the SOF only at origin.
        pop = rst_n && !q.q_empty && ((state_q == STREAM) ? (active && (q.q_data[16] == origin))
                                                          : (!q.q_data[16] || origin));
        use_data = pop && ((state_q == STREAM) || q.q_data[16]);
        // Alignment is lost when the SOF and the frame origin do not coincide.
        resync   = (state_q == STREAM) && active && (origin != head_sof);
        state_d  = resync ? WAIT_SOF : (head_sof && origin) ? STREAM : state_q;
        h_cnt_d  = (h_cnt_q == HW'(H_TOTAL - 1)) ? '0 : h_cnt_q + 1'b1;
        v_cnt_d  = (h_cnt_q != HW'(H_TOTAL - 1)) ? v_cnt_q
                 : (v_cnt_q == VW'(V_TOTAL - 1)) ? '0 : v_cnt_q + 1'b1;
        de_d     = active;
        hsync_d  = !((h_cnt_q >= HW'(H_ACTIVE + H_FP)) && (h_cnt_q < HW'(H_ACTIVE + H_FP + H_SYNC)));
        vsync_d  = !((v_cnt_q >= VW'(V_ACTIVE + V_FP)) && (v_cnt_q < VW'(V_ACTIVE + V_FP + V_SYNC)));
        rgb_d    = !active ? 16'h0000 : use_data ? q.q_data[15:0] : FILL_COLOR;
        frame_start_d = head_sof && origin;
        underrun_d    = underrun_q || ((state_q == STREAM) && active && q.q_empty);
        resync_cnt_d  = resync_cnt_q + 8'(resync && (resync_cnt_q != 8'hFF));
    end

    assign q.q_rd_en   = pop;
    assign lcd_de      = de_q;
    assign lcd_hsync   = hsync_q;
    assign lcd_vsync   = vsync_q;
    assign lcd_r       = rgb_q[15:11];
    assign lcd_g       = rgb_q[10:5];
    assign lcd_b       = rgb_q[4:0];
    assign frame_start = frame_start_q;
    assign underrun    = underrun_q;
    assign resync_cnt  = resync_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= WAIT_SOF;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            de_q          <= 1'b0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            rgb_q         <= 16'h0000;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
            resync_cnt_q  <= 8'h00;
        end else begin
            state_q       <= state_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            de_q          <= de_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            rgb_q         <= rgb_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
            resync_cnt_q  <= resync_cnt_d;
        end
    end
endmodule
